// File: rtl/axi_lite_arbiter.sv
// -----------------------------------------------------------------------------
// axi_lite_arbiter
//
// Shares one AXI4-Lite master bus between two requesters: instruction fetch on
// port 0 and load/store on port 1. Ports are granted round-robin. Exactly one
// read or write runs to completion before the next grant.
//
// Ports
//   clk, rst              rising-edge clock, synchronous active-high reset
//   pN_req                level request, held until pN_done
//   pN_we                 1 = write, 0 = read
//   pN_addr/wdata/wstrb   transaction address, write data and byte strobes
//   pN_rdata              last read data for port N, held until its next done
//   pN_done               one-cycle completion pulse
//   pN_err                valid with done, set when rresp/bresp is not OKAY
//   axi_*                 AXI4-Lite master channels AR, R, AW, W, B
//
// Every output comes straight from a flop. No AXI input reaches an output
// through combinational logic.
// -----------------------------------------------------------------------------
module axi_lite_arbiter (
    input  logic        clk,
    input  logic        rst,

    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    input  logic [3:0]  p0_wstrb,
    output logic [31:0] p0_rdata,
    output logic        p0_done,
    output logic        p0_err,

    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    input  logic [3:0]  p1_wstrb,
    output logic [31:0] p1_rdata,
    output logic        p1_done,
    output logic        p1_err,

    output logic [31:0] axi_araddr,
    output logic        axi_arvalid,
    input  logic        axi_arready,
    input  logic [31:0] axi_rdata,
    input  logic [1:0]  axi_rresp,
    input  logic        axi_rvalid,
    output logic        axi_rready,
    output logic [31:0] axi_awaddr,
    output logic        axi_awvalid,
    input  logic        axi_awready,
    output logic [31:0] axi_wdata,
    output logic [3:0]  axi_wstrb,
    output logic        axi_wvalid,
    input  logic        axi_wready,
    input  logic [1:0]  axi_bresp,
    input  logic        axi_bvalid,
    output logic        axi_bready
);

    typedef enum logic [2:0] {IDLE, RADDR, RDATA, WRITE, WRESP, DONE} state_t;

    state_t      state_q, state_d;
    logic        grant_q, grant_d;            // port being served
    logic        last_grant_q, last_grant_d;  // port served most recently
    logic        win;                         // port picked in IDLE

    logic [31:0] araddr_q, araddr_d;
    logic [31:0] awaddr_q, awaddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        arvalid_q, arvalid_d;
    logic        rready_q, rready_d;
    logic        awvalid_q, awvalid_d;
    logic        wvalid_q, wvalid_d;
    logic        bready_q, bready_d;

    logic [31:0] p0_rdata_q, p0_rdata_d;
    logic [31:0] p1_rdata_q, p1_rdata_d;
    logic        p0_done_q, p0_done_d;
    logic        p1_done_q, p1_done_d;
    logic        p0_err_q, p0_err_d;
    logic        p1_err_q, p1_err_d;

    always_comb begin
        // NOTE: every signal gets its held value first, so no path through
        // the case statement leaves one unassigned and no latch is inferred.
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        win          = 1'b0;
        araddr_d     = araddr_q;
        awaddr_d     = awaddr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        arvalid_d    = arvalid_q;
        rready_d     = rready_q;
        awvalid_d    = awvalid_q;
        wvalid_d     = wvalid_q;
        bready_d     = bready_q;
        p0_rdata_d   = p0_rdata_q;
        p1_rdata_d   = p1_rdata_q;
        p0_err_d     = p0_err_q;
        p1_err_d     = p1_err_q;
        p0_done_d    = 1'b0;
        p1_done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (p0_req || p1_req) begin
                    // On a tie the port that was not served last wins.
                    win          = (p0_req && p1_req) ? ~last_grant_q : p1_req;
                    grant_d      = win;
                    last_grant_d = win;
                    if (win ? p1_we : p0_we) begin
                        awaddr_d  = win ? p1_addr  : p0_addr;
                        wdata_d   = win ? p1_wdata : p0_wdata;
                        wstrb_d   = win ? p1_wstrb : p0_wstrb;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WRITE;
                    end else begin
                        araddr_d  = win ? p1_addr : p0_addr;
                        arvalid_d = 1'b1;
                        state_d   = RADDR;
                    end
                end
            end

            RADDR: begin
                if (axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RDATA;
                end
            end

            RDATA: begin
                if (axi_rvalid) begin
                    rready_d = 1'b0;
                    state_d  = DONE;
                    if (grant_q) begin
                        p1_rdata_d = axi_rdata;
                        p1_err_d   = |axi_rresp;
                        p1_done_d  = 1'b1;
                    end else begin
                        p0_rdata_d = axi_rdata;
                        p0_err_d   = |axi_rresp;
                        p0_done_d  = 1'b1;
                    end
                end
            end

            WRITE: begin
                // AW and W complete independently; a channel whose valid is
                // already low has finished its handshake.
                if (axi_awready) awvalid_d = 1'b0;
                if (axi_wready)  wvalid_d  = 1'b0;
                if ((!awvalid_q || axi_awready) && (!wvalid_q || axi_wready)) begin
                    bready_d = 1'b1;
                    state_d  = WRESP;
                end
            end

            WRESP: begin
                if (axi_bvalid) begin
                    bready_d = 1'b0;
                    state_d  = DONE;
                    if (grant_q) begin
                        p1_err_d  = |axi_bresp;
                        p1_done_d = 1'b1;
                    end else begin
                        p0_err_d  = |axi_bresp;
                        p0_done_d = 1'b1;
                    end
                end
            end

            DONE:    state_d = IDLE;

            default: state_d = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments make every flop take its pre-edge _d
    // value at the same instant, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;   // port 0 wins the first tie
            araddr_q     <= '0;
            awaddr_q     <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            p0_rdata_q   <= '0;
            p1_rdata_q   <= '0;
            p0_done_q    <= 1'b0;
            p1_done_q    <= 1'b0;
            p0_err_q     <= 1'b0;
            p1_err_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            araddr_q     <= araddr_d;
            awaddr_q     <= awaddr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            bready_q     <= bready_d;
            p0_rdata_q   <= p0_rdata_d;
            p1_rdata_q   <= p1_rdata_d;
            p0_done_q    <= p0_done_d;
            p1_done_q    <= p1_done_d;
            p0_err_q     <= p0_err_d;
            p1_err_q     <= p1_err_d;
        end
    end

    assign axi_araddr  = araddr_q;
    assign axi_arvalid = arvalid_q;
    assign axi_rready  = rready_q;
    assign axi_awaddr  = awaddr_q;
    assign axi_awvalid = awvalid_q;
    assign axi_wdata   = wdata_q;
    assign axi_wstrb   = wstrb_q;
    assign axi_wvalid  = wvalid_q;
    assign axi_bready  = bready_q;
    assign p0_rdata    = p0_rdata_q;
    assign p1_rdata    = p1_rdata_q;
    assign p0_done     = p0_done_q;
    assign p1_done     = p1_done_q;
    assign p0_err      = p0_err_q;
    assign p1_err      = p1_err_q;

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axi_lite_arbiter
//
// Self-checking bench for axi_lite_arbiter. One initial block drives both
// requesters and a cycle-level AXI4-Lite slave with programmable wait states.
// The expected grant, latency, read data and error flag come from a
// transaction-level model: round-robin over pending requests, and latency
// of 3 cycles plus the slave wait cycles.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axi_lite_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic [3:0]  p0_wstrb, p1_wstrb;
    logic [31:0] p0_rdata, p1_rdata;
    logic        p0_done, p0_err, p1_done, p1_err;
    logic [31:0] axi_araddr, axi_rdata, axi_awaddr, axi_wdata;
    logic        axi_arvalid, axi_arready, axi_rvalid, axi_rready;
    logic        axi_awvalid, axi_awready, axi_wvalid, axi_wready;
    logic        axi_bvalid, axi_bready;
    logic [1:0]  axi_rresp, axi_bresp;
    logic [3:0]  axi_wstrb;

    always #5 clk = ~clk;

    axi_lite_arbiter dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_wstrb(p0_wstrb), .p0_rdata(p0_rdata), .p0_done(p0_done), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_wstrb(p1_wstrb), .p1_rdata(p1_rdata), .p1_done(p1_done), .p1_err(p1_err),
        .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid),
        .axi_rready(axi_rready),
        .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid),
        .axi_wready(axi_wready),
        .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready)
    );

    typedef struct {
        bit          pend;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    int          tests = 0;
    int          fails = 0;
    req_t        rq [2];
    int          last_g;
    logic [31:0] exp_rd [2];
    int          ar_w, r_w, aw_w, w_w, b_w;
    logic [31:0] slv_rdata;
    logic [1:0]  slv_resp;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Round-robin reference: a lone request wins; on a tie the port not
    // served last wins.
    function automatic int pick(input bit r0, input bit r1);
        int w = (r0 && r1) ? 1 - last_g : (r1 ? 1 : 0);
        last_g = w;
        return w;
    endfunction

    task automatic drive_ports();
        p0_req = rq[0].pend; p0_we = rq[0].we; p0_addr = rq[0].addr;
        p0_wdata = rq[0].wdata; p0_wstrb = rq[0].wstrb;
        p1_req = rq[1].pend; p1_we = rq[1].we; p1_addr = rq[1].addr;
        p1_wdata = rq[1].wdata; p1_wstrb = rq[1].wstrb;
    endtask

    task automatic set_req(input int p, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] wstrb);
        rq[p].pend = 1'b1; rq[p].we = we; rq[p].addr = addr;
        rq[p].wdata = wdata; rq[p].wstrb = wstrb;
    endtask

    task automatic cfg_slave(input int ar, input int r, input int aw, input int w,
                             input int b, input logic [31:0] rd, input logic [1:0] resp);
        ar_w = ar; r_w = r; aw_w = aw; w_w = w; b_w = b;
        slv_rdata = rd; slv_resp = resp;
    endtask

    task automatic slave_idle();
        axi_arready = 1'b0; axi_rvalid = 1'b0; axi_awready = 1'b0;
        axi_wready = 1'b0; axi_bvalid = 1'b0;
        axi_rdata = '0; axi_rresp = '0; axi_bresp = '0;
    endtask

    // One slave step, called just after sampling at a falling edge. Each
    // channel waits its programmed number of cycles after the arbiter's
    // valid/ready appears; data and response are junk when not valid.
    task automatic slave_tick();
        axi_arready = 1'b0;
        if (axi_arvalid) begin if (ar_w == 0) axi_arready = 1'b1; else ar_w--; end
        axi_awready = 1'b0;
        if (axi_awvalid) begin if (aw_w == 0) axi_awready = 1'b1; else aw_w--; end
        axi_wready = 1'b0;
        if (axi_wvalid) begin if (w_w == 0) axi_wready = 1'b1; else w_w--; end
        axi_rvalid = 1'b0; axi_rdata = $urandom; axi_rresp = 2'($urandom);
        if (axi_rready) begin
            if (r_w == 0) begin
                axi_rvalid = 1'b1; axi_rdata = slv_rdata; axi_rresp = slv_resp;
            end else r_w--;
        end
        axi_bvalid = 1'b0; axi_bresp = 2'($urandom);
        if (axi_bready) begin
            if (b_w == 0) begin axi_bvalid = 1'b1; axi_bresp = slv_resp; end
            else b_w--;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rq[0].pend = 1'b0; rq[1].pend = 1'b0;
        drive_ports();
        slave_idle();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        last_g = 1; exp_rd[0] = '0; exp_rd[1] = '0;
    endtask

    // Called at the falling edge of cycle 0 (arbiter idle, requests driven).
    // Runs until a done pulse or a cycle budget, then checks the outcome.
    task automatic run_txn(input string tag, input int port, input bit we,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb, input int lat,
                           input logic [31:0] rdata, input bit err);
        int       done_cyc = -1;
        int       first_v = -1;
        int       ar_hs = 0, aw_hs = 0, w_hs = 0;
        bit       content_bad = 1'b0, hold_bad = 1'b0;
        logic [1:0] done_seen = 2'b00;
        logic     err_seen = 1'b0;
        logic     pv_ar = 1'b0, pr_ar = 1'b0, pv_aw = 1'b0, pr_aw = 1'b0;
        logic     pv_w = 1'b0, pr_w = 1'b0;
        for (int cyc = 1; cyc <= 80; cyc++) begin
            @(negedge clk);
            if (first_v < 0 && (axi_arvalid || axi_awvalid || axi_wvalid)) first_v = cyc;
            if (axi_arvalid && axi_araddr !== addr) content_bad = 1'b1;
            if (axi_awvalid && axi_awaddr !== addr) content_bad = 1'b1;
            if (axi_wvalid && (axi_wdata !== wdata || axi_wstrb !== wstrb)) content_bad = 1'b1;
            if ((pv_ar && !pr_ar && !axi_arvalid) || (pv_aw && !pr_aw && !axi_awvalid) ||
                (pv_w && !pr_w && !axi_wvalid)) hold_bad = 1'b1;
            if (p0_done || p1_done) begin
                done_cyc  = cyc;
                done_seen = {p1_done, p0_done};
                err_seen  = port[0] ? p1_err : p0_err;
            end
            slave_tick();
            if (axi_arvalid && axi_arready) ar_hs++;
            if (axi_awvalid && axi_awready) aw_hs++;
            if (axi_wvalid && axi_wready) w_hs++;
            pv_ar = axi_arvalid; pr_ar = axi_arready;
            pv_aw = axi_awvalid; pr_aw = axi_awready;
            pv_w  = axi_wvalid;  pr_w  = axi_wready;
            if (done_cyc > 0) break;
        end
        if (!we) exp_rd[port] = rdata;
        chk({tag, " first_valid_cycle"}, first_v, 1);
        chk({tag, " done_cycle"}, done_cyc, lat);
        chk({tag, " done_port"}, done_seen, port[0] ? 2'b10 : 2'b01);
        chk({tag, " err"}, err_seen, err);
        chk({tag, " channel_content"}, content_bad, 0);
        chk({tag, " valid_held_until_ready"}, hold_bad, 0);
        chk({tag, " handshakes"}, ar_hs * 100 + aw_hs * 10 + w_hs, we ? 11 : 100);
        chk({tag, " p0_rdata"}, p0_rdata, exp_rd[0]);
        chk({tag, " p1_rdata"}, p1_rdata, exp_rd[1]);
    endtask

    // Serve the pending requests according to the model.
    task automatic serve(input string tag, output int w);
        int lat;
        w = pick(rq[0].pend, rq[1].pend);
        lat = rq[w].we ? 3 + ((aw_w > w_w) ? aw_w : w_w) + b_w : 3 + ar_w + r_w;
        run_txn(tag, w, rq[w].we, rq[w].addr, rq[w].wdata, rq[w].wstrb, lat,
                slv_rdata, slv_resp != 2'b00);
    endtask

    // The cycle after done: arbiter back in IDLE with a quiet bus.
    task automatic idle_step(input string tag);
        @(negedge clk);
        chk({tag, " done_one_cycle"}, {p1_done, p0_done}, 0);
        chk({tag, " idle_bus"}, {axi_arvalid, axi_rready, axi_awvalid, axi_wvalid, axi_bready}, 0);
        slave_tick();
    endtask

    initial begin
        int  w;
        bit  seen;
        rq[0] = '{1'b0, 1'b0, 32'h0, 32'h0, 4'h0};
        rq[1] = '{1'b0, 1'b0, 32'h0, 32'h0, 4'h0};
        cfg_slave(0, 0, 0, 0, 0, 32'h0, 2'b00);
        do_reset();

        // Reset values
        chk("reset valid_ready", {axi_arvalid, axi_rready, axi_awvalid, axi_wvalid, axi_bready}, 0);
        chk("reset araddr", axi_araddr, 0);
        chk("reset awaddr", axi_awaddr, 0);
        chk("reset wdata_wstrb", {axi_wdata, axi_wstrb}, 0);
        chk("reset rdata", {p0_rdata, p1_rdata}, 0);
        chk("reset done_err", {p0_done, p1_done, p0_err, p1_err}, 0);

        // p0 read, zero-wait slave
        set_req(0, 1'b0, 32'h0000_1000, 32'h0, 4'h0);
        drive_ports();
        cfg_slave(0, 0, 0, 0, 0, 32'hDEAD_BEEF, 2'b00);
        serve("p0_read", w);
        rq[w].pend = 1'b0; drive_ports();
        idle_step("p0_read");

        // p1 write, W accepted 2 cycles before AW, SLVERR response
        set_req(1, 1'b1, 32'h0000_2004, 32'h1234_5678, 4'b0011);
        drive_ports();
        cfg_slave(0, 0, 2, 0, 0, 32'h0, 2'b10);
        serve("p1_write_slverr", w);
        rq[w].pend = 1'b0; drive_ports();
        idle_step("p1_write_slverr");

        // arready held low for 5 cycles
        set_req(0, 1'b0, 32'h0000_3000, 32'h0, 4'h0);
        drive_ports();
        cfg_slave(5, 0, 0, 0, 0, 32'hCAFE_F00D, 2'b00);
        serve("arready_wait5", w);
        rq[w].pend = 1'b0; drive_ports();
        idle_step("arready_wait5");

        // Both ports requesting continuously from reset: grants alternate
        do_reset();
        set_req(0, 1'b0, 32'h0000_4000, 32'h0, 4'h0);
        set_req(1, 1'b0, 32'h0000_4100, 32'h0, 4'h0);
        drive_ports();
        for (int k = 0; k < 4; k++) begin
            cfg_slave(0, 0, 0, 0, 0, 32'hA000_0000 + 32'(k), 2'b00);
            serve($sformatf("round_robin%0d", k), w);
            rq[w].addr = rq[w].addr + 32'd4;
            drive_ports();
            idle_step("round_robin");
        end

        // Reset while in RDATA with rvalid low
        do_reset();
        set_req(0, 1'b0, 32'h0000_5000, 32'h0, 4'h0);
        drive_ports();
        cfg_slave(0, 10, 0, 0, 0, 32'h1111_2222, 2'b00);
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (axi_rready) begin seen = 1'b1; break; end
            slave_tick();
        end
        chk("midreset reached_rdata", seen, 1);
        rst = 1'b1;
        rq[0].pend = 1'b0; drive_ports();
        slave_idle();
        @(negedge clk);
        chk("midreset valid_ready", {axi_arvalid, axi_rready, axi_awvalid, axi_wvalid, axi_bready}, 0);
        chk("midreset no_done", {p0_done, p1_done}, 0);
        rst = 1'b0;
        last_g = 1; exp_rd[0] = '0; exp_rd[1] = '0;
        set_req(1, 1'b0, 32'h0000_6000, 32'h0, 4'h0);
        drive_ports();
        cfg_slave(0, 0, 0, 0, 0, 32'h0BAD_F00D, 2'b00);
        serve("after_reset_p1_read", w);
        rq[w].pend = 1'b0; drive_ports();
        idle_step("after_reset_p1_read");

        // Randomized traffic: the loser keeps its request until served
        for (int n = 0; n < 40; n++) begin
            for (int p = 0; p < 2; p++) begin
                if (!rq[p].pend && $urandom_range(0, 1) == 1)
                    set_req(p, 1'($urandom), $urandom & 32'hFFFF_FFFC, $urandom, 4'($urandom));
                else if (!rq[p].pend) begin
                    rq[p].addr = $urandom; rq[p].we = 1'($urandom);
                end
            end
            if (!rq[0].pend && !rq[1].pend)
                set_req($urandom_range(0, 1), 1'($urandom), $urandom & 32'hFFFF_FFFC,
                        $urandom, 4'($urandom));
            drive_ports();
            cfg_slave($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 3), $urandom,
                      ($urandom_range(0, 1) == 1) ? 2'b00 : 2'($urandom_range(1, 3)));
            serve($sformatf("rnd%0d", n), w);
            rq[w].pend = 1'b0; drive_ports();
            idle_step("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
